// File: rtl/gram_dfii_wb_responder.sv
// Wishbone-to-DFI software control port: register window driving phase-0 DFI.
// Optional read-data capture path enabled by defining GRAM_DFII_RDDATA_EN.
module gram_dfii_wb_responder #(
  parameter logic [29:0] BASE = 30'h2400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  output logic [31:0] wb_dat_r,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic        wb_ack,
  output logic [13:0] dfi_address,
  output logic [2:0]  dfi_bank,
  output logic        dfi_cs_n,
  output logic        dfi_we_n,
  output logic        dfi_cas_n,
  output logic        dfi_ras_n,
  output logic        dfi_cke,
  output logic        dfi_odt,
  output logic        dfi_reset_n,
  output logic        hw_sel
`ifdef GRAM_DFII_RDDATA_EN
  ,
  input  logic [31:0] dfi_rddata,
  input  logic        dfi_rddata_valid,
  output logic        dfi_rddata_en,
  output logic        dfi_wrdata_en
`endif
);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        hit;
  logic [2:0]  off;
  logic        commit;
  logic        wr;
  logic        issue_go;
  logic        pend;
  logic [31:0] rd_val;
  logic [3:0]  ctrl;
  logic [5:0]  cmd;
  logic [13:0] addr;
  logic [2:0]  bank;
  logic [31:0] rdd;
  logic        unused_bits;

  assign unused_bits = ^{wb_dat_w[31:14], wb_sel[3:2]};

  assign hit    = wb_cyc & wb_stb & (wb_adr[29:3] == BASE[29:3]);
  assign off    = wb_adr[2:0];
  assign commit = (state_q == IDLE) & hit;
  assign wr     = commit & wb_we;
  assign wb_ack = (state_q == ACK);

  assign issue_go = wr & (off == 3'd2)
                  & wb_sel[0] & wb_dat_w[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hit) state_d = ACK;
      ACK:  state_d = IDLE;
    endcase
  end

`ifdef GRAM_DFII_RDDATA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdd <= '0;
    end else if (dfi_rddata_valid) begin
      rdd <= dfi_rddata;
    end
  end
`else
  assign rdd = '0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      off == 3'd0: rd_val = {28'd0, ctrl};
      off == 3'd1: rd_val = {26'd0, cmd};
      off == 3'd3: rd_val = {18'd0, addr};
      off == 3'd4: rd_val = {29'd0, bank};
      off == 3'd6: rd_val = rdd;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wb_dat_r <= '0;
    end else begin
      state_q  <= state_d;
      wb_dat_r <= commit ? rd_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      cmd  <= '0;
      addr <= '0;
      bank <= '0;
    end else if (wr) begin
      if (off == 3'd0 && wb_sel[0])
        ctrl <= wb_dat_w[3:0];
      if (off == 3'd1 && wb_sel[0])
        cmd <= wb_dat_w[5:0];
      if (off == 3'd3 && wb_sel[0])
        addr[7:0] <= wb_dat_w[7:0];
      if (off == 3'd3 && wb_sel[1])
        addr[13:8] <= wb_dat_w[13:8];
      if (off == 3'd4 && wb_sel[0])
        bank <= wb_dat_w[2:0];
    end
  end

  // pend marks the ACK cycle; the command fires on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      dfi_cs_n  <= 1'b1;
      dfi_we_n  <= 1'b1;
      dfi_cas_n <= 1'b1;
      dfi_ras_n <= 1'b1;
    end else begin
      pend      <= issue_go;
      dfi_cs_n  <= ~(pend & cmd[0]);
      dfi_we_n  <= ~(pend & cmd[1]);
      dfi_cas_n <= ~(pend & cmd[2]);
      dfi_ras_n <= ~(pend & cmd[3]);
    end
  end

`ifdef GRAM_DFII_RDDATA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dfi_rddata_en <= 1'b0;
      dfi_wrdata_en <= 1'b0;
    end else begin
      dfi_rddata_en <= pend & cmd[5];
      dfi_wrdata_en <= pend & cmd[4];
    end
  end
`endif

  assign dfi_address = addr;
  assign dfi_bank    = bank;
  assign hw_sel      = ctrl[0];
  assign dfi_cke     = ctrl[1];
  assign dfi_odt     = ctrl[2];
  assign dfi_reset_n = ctrl[3];

endmodule

// File: tb/tb_gram_dfii_wb_responder.sv
// Randomized bench for gram_dfii_wb_responder against a register-map model.
// Define GRAM_DFII_RDDATA_EN to also exercise the read-data path.
module tb_gram_dfii_wb_responder;

  localparam logic [29:0] BASE_T = 30'h2400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel = '0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic        wb_ack;
  logic [13:0] dfi_address;
  logic [2:0]  dfi_bank;
  logic        dfi_cs_n, dfi_we_n;
  logic        dfi_cas_n, dfi_ras_n;
  logic        dfi_cke, dfi_odt;
  logic        dfi_reset_n, hw_sel;
`ifdef GRAM_DFII_RDDATA_EN
  logic [31:0] dfi_rddata = '0;
  logic        dfi_rddata_valid = 1'b0;
  logic        dfi_rddata_en, dfi_wrdata_en;
`endif

  gram_dfii_wb_responder #(.BASE(BASE_T)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w),
    .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_ack(wb_ack),
    .dfi_address(dfi_address),
    .dfi_bank(dfi_bank),
    .dfi_cs_n(dfi_cs_n), .dfi_we_n(dfi_we_n),
    .dfi_cas_n(dfi_cas_n), .dfi_ras_n(dfi_ras_n),
    .dfi_cke(dfi_cke), .dfi_odt(dfi_odt),
    .dfi_reset_n(dfi_reset_n), .hw_sel(hw_sel)
`ifdef GRAM_DFII_RDDATA_EN
    ,
    .dfi_rddata(dfi_rddata),
    .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_rddata_en(dfi_rddata_en),
    .dfi_wrdata_en(dfi_wrdata_en)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // model state
  logic [3:0]  m_ctrl = '0;
  logic [5:0]  m_cmd = '0;
  logic [13:0] m_addr = '0;
  logic [2:0]  m_bank = '0;
  logic [31:0] m_rdd = '0;
  int          exp_ack_cyc = -1;
  int          exp_pulse_cyc = -1;
  logic [31:0] exp_rd = '0;
  logic [5:0]  p_cmd = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0: return {28'd0, m_ctrl};
      3'd1: return {26'd0, m_cmd};
      3'd3: return {18'd0, m_addr};
      3'd4: return {29'd0, m_bank};
`ifdef GRAM_DFII_RDDATA_EN
      3'd6: return m_rdd;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] dat,
                                        input logic [3:0] sel,
                                        input int width);
    logic [31:0] lm;
    logic [31:0] wm;
    for (int i = 0; i < 4; i++) lm[i*8 +: 8] = {8{sel[i]}};
    wm = (32'h1 << width) - 32'h1;
    return ((old & ~lm) | (dat & lm)) & wm;
  endfunction

  task automatic m_write(input logic [2:0] off,
                         input logic [31:0] dat,
                         input logic [3:0] sel);
    logic [31:0] t;
    case (off)
      3'd0: begin t = merge({28'd0, m_ctrl}, dat, sel, 4); m_ctrl = t[3:0]; end
      3'd1: begin t = merge({26'd0, m_cmd}, dat, sel, 6); m_cmd = t[5:0]; end
      3'd3: begin t = merge({18'd0, m_addr}, dat, sel, 14); m_addr = t[13:0]; end
      3'd4: begin t = merge({29'd0, m_bank}, dat, sel, 3); m_bank = t[2:0]; end
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_cmd = '0; m_addr = '0;
    m_bank = '0; m_rdd = '0;
    exp_ack_cyc = -1; exp_pulse_cyc = -1;
  endtask

  // cycle-by-cycle compare against the model
  initial begin
    logic e_ack, e_pulse;
    forever begin
      @(posedge clk);
      #1;
      e_ack   = (cyc == exp_ack_cyc);
      e_pulse = (cyc == exp_pulse_cyc);
      chk("ack", {31'd0, wb_ack}, {31'd0, e_ack});
      chk("dat_r", wb_dat_r, e_ack ? exp_rd : 32'd0);
      chk("cmd_n", {28'd0, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cs_n},
          {28'd0, e_pulse ? ~p_cmd[3:0] : 4'hF});
      chk("address", {18'd0, dfi_address}, {18'd0, m_addr});
      chk("bank", {29'd0, dfi_bank}, {29'd0, m_bank});
      chk("static", {28'd0, dfi_reset_n, dfi_odt, dfi_cke, hw_sel},
          {28'd0, m_ctrl});
`ifdef GRAM_DFII_RDDATA_EN
      chk("data_en", {30'd0, dfi_rddata_en, dfi_wrdata_en},
          {30'd0, e_pulse & p_cmd[5], e_pulse & p_cmd[4]});
`endif
    end
  end

  task automatic access(input logic [29:0] adr,
                        input logic [31:0] dat,
                        input logic [3:0] sel,
                        input logic we,
                        input int hold,
                        output logic [31:0] rd);
    logic h;
    logic [2:0] off;
    @(negedge clk);
    wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    h   = (adr[29:3] == BASE_T[29:3]);
    off = adr[2:0];
    rd  = '0;
    if (h) begin
      exp_ack_cyc = cyc + 1;
      exp_rd = m_read(off);
      if (we && off == 3'd2 && sel[0] && dat[0]) begin
        exp_pulse_cyc = cyc + 2;
        p_cmd = m_cmd;
      end
      @(posedge clk);
      if (we) m_write(off, dat, sel);
      @(negedge clk);
      rd = wb_dat_r;
      repeat (hold) @(negedge clk);
    end else begin
      repeat (hold + 1) @(negedge clk);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] d;
    access(BASE_T + 30'(off), dat, sel, 1'b1, 0, d);
  endtask

  task automatic rdr(input logic [2:0] off, output logic [31:0] d);
    access(BASE_T + 30'(off), 32'd0, 4'hF, 1'b0, 0, d);
  endtask

  task automatic cmd_now(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cs_n},
        {28'd0, exp});
  endtask

`ifdef GRAM_DFII_RDDATA_EN
  task automatic rddata_pulse(input logic [31:0] v);
    @(negedge clk);
    dfi_rddata = v; dfi_rddata_valid = 1'b1;
    @(posedge clk);
    m_rdd = v;
    @(negedge clk);
    dfi_rddata_valid = 1'b0;
  endtask
`endif

  initial begin
    logic [31:0] d;
    logic [29:0] a;
    logic [2:0]  o;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_static", {28'd0, dfi_reset_n, dfi_odt, dfi_cke, hw_sel}, 32'd0);

    // reset while a CONTROL write is being presented
    wr(3'd0, 32'h0F, 4'hF);
    chk("ctrl_set_rst_n", {31'd0, dfi_reset_n}, 32'd1);
    @(negedge clk);
    wb_adr = BASE_T; wb_dat_w = 32'h0F; wb_sel = 4'hF;
    wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    #2 rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rdr(3'd0, d);
    chk("ctrl_after_reset", d, 32'd0);
    chk("rst_n_after_reset", {31'd0, dfi_reset_n}, 32'd0);

    wr(3'd0, 32'h0C, 4'hF);
    chk("ctrl_0c", {29'd0, dfi_reset_n, dfi_odt, dfi_cke}, 32'b110);
    wr(3'd0, 32'h0E, 4'hF);
    chk("ctrl_0e_cke", {31'd0, dfi_cke}, 32'd1);
    rdr(3'd0, d);
    chk("ctrl_readback", d, 32'h0E);

    wr(3'd3, 32'h200, 4'hF);
    wr(3'd4, 32'h2, 4'hF);
    wr(3'd1, 32'h0F, 4'hF);
    wr(3'd2, 32'h1, 4'hF);
    cmd_now("pulse0f_before", 4'hF);
    @(negedge clk);
    cmd_now("pulse0f", 4'h0);
    chk("pulse0f_addr", {18'd0, dfi_address}, 32'h200);
    chk("pulse0f_bank", {29'd0, dfi_bank}, 32'd2);
    @(negedge clk);
    cmd_now("pulse0f_after", 4'hF);

    wr(3'd3, 32'h400, 4'hF);
    wr(3'd1, 32'h03, 4'hF);
    wr(3'd2, 32'h1, 4'hF);
    @(negedge clk);
    cmd_now("pulse03", 4'b1100);
    wr(3'd2, 32'h0, 4'hF);
    @(negedge clk);
    cmd_now("issue0_none", 4'hF);
    rdr(3'd2, d);
    chk("issue_reads0", d, 32'd0);

    wr(3'd3, 32'h0, 4'hF);
    wr(3'd3, 32'hFFFF_FFFF, 4'b0001);
    rdr(3'd3, d);
    chk("addr_lane0", d, 32'h00FF);
    access(BASE_T + 30'd8, 32'h1, 4'hF, 1'b0, 20, d);

`ifdef GRAM_DFII_RDDATA_EN
    wr(3'd1, 32'h2D, 4'hF);
    wr(3'd2, 32'h1, 4'hF);
    @(negedge clk);
    chk("rddata_en", {31'd0, dfi_rddata_en}, 32'd1);
    rddata_pulse(32'hFACE_CA8C);
    rdr(3'd6, d);
    chk("rddata_rb", d, 32'hFACE_CA8C);
`else
    rdr(3'd6, d);
    chk("rddata_off", d, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = BASE_T + 30'd8 + 30'($urandom_range(0, 15));
        1:       a = BASE_T - 30'd1 - 30'($urandom_range(0, 7));
        2:       a = 30'($urandom);
        default: a = BASE_T + 30'(o);
      endcase
      access(a, $urandom, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 1), d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef GRAM_DFII_RDDATA_EN
      if ($urandom_range(0, 7) == 0) rddata_pulse($urandom);
`endif
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
